// File: rtl/cmsdk_apb_wdog_mc_pkg.sv
// cmsdk_apb_wdog_mc_pkg: register map, unlock key, ID bytes and CTRL bit positions
package cmsdk_apb_wdog_mc_pkg;
    typedef enum logic [2:0] {
        REG_LOAD, REG_VALUE, REG_CTRL, REG_INTCLR, REG_RIS, REG_MIS, REG_WINDOW, REG_NONE
    } reg_e;
    localparam int CTRL_INTEN = 0;
    localparam int CTRL_RESEN = 1;
    localparam int CTRL_WINEN = 2;
    localparam logic [9:0]  LOCK_WADDR = 10'h300;
    localparam logic [5:0]  ID_WPAGE   = 6'h3F;
    localparam logic [31:0] UNLOCK_KEY = 32'h1ACCE551;
    localparam logic [7:0]  PID4 = 8'h04;
    localparam logic [7:0]  PID0 = 8'h25;
    localparam logic [7:0]  PID1 = 8'hB8;
    localparam logic [7:0]  PID2 = 8'h1B;
    localparam logic [7:0]  PID3 = 8'h00;
    localparam logic [7:0]  CID0 = 8'h0D;
    localparam logic [7:0]  CID1 = 8'hF0;
    localparam logic [7:0]  CID2 = 8'h05;
    localparam logic [7:0]  CID3 = 8'hB1;
    function automatic logic [7:0] id_byte(input logic [3:0] idx);
        return idx == 4'd4  ? PID4 :
               idx == 4'd8  ? PID0 :
               idx == 4'd9  ? PID1 :
               idx == 4'd10 ? PID2 :
               idx == 4'd11 ? PID3 :
               idx == 4'd12 ? CID0 :
               idx == 4'd13 ? CID1 :
               idx == 4'd14 ? CID2 :
               idx == 4'd15 ? CID3 : 8'h00;
    endfunction
endpackage

// File: rtl/cmsdk_apb_wdog_mc_chan.sv
// cmsdk_apb_wdog_mc_chan: one watchdog channel with counter, window check and sticky reset causes
module cmsdk_apb_wdog_mc_chan
    import cmsdk_apb_wdog_mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             wr_load,
    input  logic             wr_ctrl,
    input  logic             wr_intclr,
    input  logic             wr_window,
    input  logic [CNT_W-1:0] wdata,
    input  logic [2:0]       wctrl,
    output logic [CNT_W-1:0] load,
    output logic [CNT_W-1:0] value,
    output logic [2:0]       ctrl,
    output logic [CNT_W-1:0] window,
    output logic             ris,
    output logic             mis,
    output logic             res_req,
    output logic [1:0]       cause
);
    logic [CNT_W-1:0] load_q, load_d, value_q, value_d, window_q, window_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic             ris_q, ris_d, to_q, to_d, win_q, win_d;
    logic             tick, zero, timeout;

    always_comb begin
        tick     = ctrl_q[CTRL_INTEN] & clk_en;
        zero     = value_q == '0;
        // a refresh landing on the expiry cycle cancels that expiry
        timeout  = tick & zero & ~wr_intclr;
        load_d   = wr_load ? wdata : load_q;
        ctrl_d   = wr_ctrl ? wctrl : ctrl_q;
        window_d = wr_window ? wdata : window_q;
        value_d  = wr_load   ? wdata :
                   wr_intclr ? load_q :
                   tick      ? (zero ? load_q : value_q - CNT_W'(1)) : value_q;
        ris_d    = wr_intclr ? 1'b0 : ris_q | timeout;
        to_d     = to_q | (timeout & ris_q & ctrl_q[CTRL_RESEN]);
        win_d    = win_q | (wr_intclr & ctrl_q[CTRL_WINEN] & (value_q > window_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q   <= '1;
            value_q  <= '1;
            ctrl_q   <= '0;
            window_q <= '0;
            ris_q    <= 1'b0;
            to_q     <= 1'b0;
            win_q    <= 1'b0;
        end else begin
            load_q   <= load_d;
            value_q  <= value_d;
            ctrl_q   <= ctrl_d;
            window_q <= window_d;
            ris_q    <= ris_d;
            to_q     <= to_d;
            win_q    <= win_d;
        end
    end

    assign load    = load_q;
    assign value   = value_q;
    assign ctrl    = ctrl_q;
    assign window  = window_q;
    assign ris     = ris_q;
    assign mis     = ris_q & ctrl_q[CTRL_INTEN];
    assign res_req = to_q | win_q;
    assign cause   = {win_q, to_q};
endmodule

// File: rtl/cmsdk_apb_wdog_mc.sv
// cmsdk_apb_wdog_mc: multi-channel APB watchdog with lock, ID space and windowed refresh
module cmsdk_apb_wdog_mc
    import cmsdk_apb_wdog_mc_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [11:2]         PADDR,
    input  logic [31:0]         PWDATA,
    output logic [31:0]         PRDATA,
    output logic                PREADY,
    output logic                PSLVERR,
    input  logic                WDOGCLKEN,
    output logic [NUM_CH-1:0]   WDOGINT,
    output logic                WDOGRES,
    output logic [2*NUM_CH-1:0] RESCAUSE
);
    logic [CNT_W-1:0]  load_v [NUM_CH];
    logic [CNT_W-1:0]  value_v [NUM_CH];
    logic [CNT_W-1:0]  window_v [NUM_CH];
    logic [2:0]        ctrl_v [NUM_CH];
    logic [NUM_CH-1:0] ris_v, mis_v, req_v, ch_wr;
    logic [6:0]        ch_idx;
    reg_e              reg_sel;
    logic              wr, rd, ch_hit, chan_reg, ro, slv_err, lock_q, lock_d;
    logic [31:0]       rdata;

    always_comb begin
        wr       = PSEL & PENABLE & PWRITE;
        rd       = PSEL & PENABLE & ~PWRITE;
        ch_idx   = PADDR[11:5];
        reg_sel  = reg_e'(PADDR[4:2]);
        ch_hit   = ch_idx < 7'(NUM_CH);
        chan_reg = ch_hit & (reg_sel != REG_NONE);
        ro       = reg_sel inside {REG_VALUE, REG_RIS, REG_MIS};
        slv_err  = wr & chan_reg & (lock_q | ro);
        lock_d   = (wr && PADDR == LOCK_WADDR) ? PWDATA != UNLOCK_KEY : lock_q;
        ch_wr    = '0;
        for (int n = 0; n < NUM_CH; n++)
            ch_wr[n] = wr & chan_reg & ~slv_err & (ch_idx == 7'(n));
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            lock_q <= 1'b0;
        else
            lock_q <= lock_d;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        cmsdk_apb_wdog_mc_chan #(.CNT_W(CNT_W)) u_chan (
            .clk       (PCLK),
            .rst_n     (PRESETn),
            .clk_en    (WDOGCLKEN),
            .wr_load   (ch_wr[i] && reg_sel == REG_LOAD),
            .wr_ctrl   (ch_wr[i] && reg_sel == REG_CTRL),
            .wr_intclr (ch_wr[i] && reg_sel == REG_INTCLR),
            .wr_window (ch_wr[i] && reg_sel == REG_WINDOW),
            .wdata     (PWDATA[CNT_W-1:0]),
            .wctrl     (PWDATA[2:0]),
            .load      (load_v[i]),
            .value     (value_v[i]),
            .ctrl      (ctrl_v[i]),
            .window    (window_v[i]),
            .ris       (ris_v[i]),
            .mis       (mis_v[i]),
            .res_req   (req_v[i]),
            .cause     (RESCAUSE[2*i+:2])
        );
    end

    always_comb begin
        rdata = '0;
        for (int n = 0; n < NUM_CH; n++)
            if (ch_hit && ch_idx == 7'(n))
                rdata = reg_sel == REG_LOAD   ? 32'(load_v[n])   :
                        reg_sel == REG_VALUE  ? 32'(value_v[n])  :
                        reg_sel == REG_CTRL   ? 32'(ctrl_v[n])   :
                        reg_sel == REG_RIS    ? 32'(ris_v[n])    :
                        reg_sel == REG_MIS    ? 32'(mis_v[n])    :
                        reg_sel == REG_WINDOW ? 32'(window_v[n]) : 32'h0;
        if (PADDR == LOCK_WADDR)
            rdata = {31'h0, lock_q};
        if (PADDR[11:6] == ID_WPAGE)
            rdata = {24'h0, id_byte(PADDR[5:2])};
    end

    assign PRDATA  = (PRESETn && rd) ? rdata : 32'h0;
    assign PSLVERR = PRESETn & slv_err;
    assign PREADY  = 1'b1;
    assign WDOGINT = mis_v;
    assign WDOGRES = |req_v;
endmodule

// File: doc/cmsdk_apb_wdog_mc.md
CMSDK_APB_WDOG_MC -- requirements
Module: cmsdk_apb_wdog_mc

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent watchdog channels, legal range 1..4.
REQ-002 Parameter CNT_W, default 32: counter, LOAD and WINDOW width, legal range 8..32; narrower registers read zero-extended.
REQ-003 PCLK  in  1  sole clock for APB and counters.
REQ-004 PRESETn  in  1  reset, asynchronous assert, active-low.
REQ-005 PSEL, PENABLE, PWRITE  in  1 each  APB control.
REQ-006 PADDR  in  [11:2]  APB word address.
REQ-007 PWDATA  in  32  APB write data.
REQ-008 PRDATA  out  32  APB read data.
REQ-009 PREADY  out  1  tied high, zero wait states.
REQ-010 PSLVERR  out  1  access-phase error flag.
REQ-011 WDOGCLKEN  in  1  count enable, sampled on PCLK.
REQ-012 WDOGINT  out  [NUM_CH-1:0]  per-channel interrupt, equals MIS.
REQ-013 WDOGRES  out  1  OR of all channel reset requests.
REQ-014 RESCAUSE  out  [2*NUM_CH-1:0]  per channel {window violation, timeout}, sticky.

Function
REQ-015 Channel n base = n*0x20: +0x00 LOAD RW, +0x04 VALUE RO, +0x08 CTRL RW {bit2 WINEN, bit1 RESEN, bit0 INTEN}, +0x0C INTCLR WO, +0x10 RIS RO, +0x14 MIS RO, +0x18 WINDOW RW.
REQ-016 0xC00 LOCK: writing 0x1ACCE551 clears lock, any other value sets it; read returns lock bit.
REQ-017 0xFD0..0xFFC ID: PID4 0x04, PID0 0x25, PID1 0xB8, PID2 0x1B, PID3 0x00, CID0..3 0x0D, 0xF0, 0x05, 0xB1; others 0x00.
REQ-018 Writes take effect on access-phase PCLK edge (PSEL & PENABLE & PWRITE); reads are combinational in access phase; unmapped and out-of-range-channel reads return 0.
REQ-019 PSLVERR = 1 on access-phase write to any channel register while locked, or to VALUE/RIS/MIS; such writes are ignored.
REQ-020 LOAD write: VALUE <= written value on that edge, overriding any same-cycle decrement.
REQ-021 When INTEN = 1 and WDOGCLKEN = 1: VALUE decrements by 1 per cycle.
REQ-022 When INTEN = 0: counter holds.
REQ-023 Counter reaching 0 with WDOGCLKEN = 1 and RIS = 0: sets RIS and reloads LOAD.
REQ-024 Counter reaching 0 with WDOGCLKEN = 1 and RIS = 1: reloads LOAD; if RESEN = 1, sets timeout reset request.
REQ-025 INTCLR write (any data): clears RIS and reloads VALUE <= LOAD; RIS clear wins over a same-cycle set.
REQ-026 Windowed refresh: INTCLR with WINEN = 1 and VALUE > WINDOW sets window-violation reset request, regardless of RESEN; the refresh still reloads.
REQ-027 MIS = RIS & INTEN.
REQ-028 Reset requests and RESCAUSE bits are sticky until PRESETn; WDOGRES asserts the cycle after the request edge, registered.
REQ-029 LOAD = 0: counter reloads 0 each enabled cycle, giving interrupt next enabled cycle; same rules as REQ-023/024 apply.
REQ-030 Channels are fully independent; simultaneous events on different channels all take effect.

Reset
REQ-031 On PRESETn low: LOAD and VALUE all-ones (CNT_W bits); CTRL, WINDOW, RIS, lock, reset requests and RESCAUSE 0.
REQ-032 Outputs during reset: WDOGINT = 0, WDOGRES = 0, PSLVERR = 0, PRDATA = 0.
REQ-033 Reset asserted mid-count aborts immediately; no event is generated on release.

Structure
REQ-034 Package cmsdk_apb_wdog_mc_pkg holds register offsets, unlock key, ID byte constants and CTRL bit indices.
REQ-035 One sub-module cmsdk_apb_wdog_mc_chan (counter, LOAD, CTRL, WINDOW, RIS, reset request) is instantiated NUM_CH times by generate; the top holds decode, lock, ID and read mux.

Verification
REQ-036 Ch0 LOAD=3, CTRL=1, WDOGCLKEN=1 -> RIS set 4 cycles after the write edge, VALUE reads 3 again, WDOGINT[0]=1.
REQ-037 Ch0 CTRL=3, LOAD=2, no INTCLR -> WDOGRES=1 after second timeout, RESCAUSE[0]=1, held until PRESETn.
REQ-038 Ch1 CTRL=7, LOAD=100, WINDOW=50, INTCLR at VALUE=80 -> WDOGRES=1, RESCAUSE[3]=1; the same sequence with INTCLR at VALUE=40 gives no reset.
REQ-039 LOCK write 0x0 then CTRL write -> PSLVERR=1, CTRL unchanged; LOCK=0x1ACCE551 then CTRL write succeeds with PSLVERR=0.
REQ-040 INTCLR in the same cycle the counter hits 0 with RIS=1 -> RIS=0, no reset request, VALUE=LOAD.
REQ-041 NUM_CH=4, CNT_W=16: LOAD=0x12345 on ch3 -> reads 0x2345; ID reads 0xFE0 -> 0x25, 0xFFC -> 0xB1.
